// File: rtl/rast_tri_sched.sv
// Two-requester triangle scheduler in front of rast: arbitrates issue, tags each triangle
// with its requester ID and steers hit subsequences back. Optional RAST_TRI_SCHED_FIXED_PRIO_EN.
module rast_tri_sched #(
  parameter int SIGFIG    = 24,
  parameter int VERTS     = 3,
  parameter int AXIS      = 3,
  parameter int COLORS    = 3,
  parameter int OUT_DELAY = 5,
  parameter int TAG_DEPTH = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [1:0]                                     req_valid,
  output logic [1:0]                                     req_ready,
  input  logic signed [1:0][VERTS-1:0][AXIS-1:0][SIGFIG-1:0] req_tri,
  input  logic [1:0][COLORS-1:0][SIGFIG-1:0]             req_color,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]  tri_R10S,
  output logic [COLORS-1:0][SIGFIG-1:0]                  color_R10U,
  output logic                                           validTri_R10H,
  input  logic                                           halt_RnnnnL,
  input  logic                                           hit_valid_R18H,
  input  logic signed [AXIS-1:0][SIGFIG-1:0]             hit_R18S,
  input  logic [COLORS-1:0][SIGFIG-1:0]                  color_R18U,
  output logic [1:0]                                     hit_valid_o,
  output logic signed [AXIS-1:0][SIGFIG-1:0]             hit_o,
  output logic [COLORS-1:0][SIGFIG-1:0]                  color_o,
  output logic [1:0]                                     done_o,
  output logic                                           err_o
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [1:0]           grant;
  logic                 can_issue;
  logic                 push;
  logic                 pop;
  logic                 tag_full;
  logic                 tag_empty;
  logic                 head;
  logic [TAG_DEPTH-1:0] tag_mem;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [OUT_DELAY-1:0] halt_p;
  logic                 halt_d;
  logic                 halt_d1;
  logic                 first_seen;
  logic                 end_evt;
  logic                 hit_act;

  assign tag_full  = (count == CNT_W'(TAG_DEPTH));
  assign tag_empty = (count == '0);
  assign can_issue = halt_RnnnnL & ~tag_full;
  assign push      = |grant;
  assign head      = tag_mem[rd_ptr];

`ifdef RAST_TRI_SCHED_FIXED_PRIO_EN
  always_comb begin
    grant    = '0;
    grant[0] = can_issue & req_valid[0];
    grant[1] = can_issue & req_valid[1] & ~req_valid[0];
  end
`else
  logic rr;

  always_comb begin
    grant = '0;
    if (rr) begin
      grant[1] = can_issue & req_valid[1];
      grant[0] = can_issue & req_valid[0] & ~req_valid[1];
    end else begin
      grant[0] = can_issue & req_valid[0];
      grant[1] = can_issue & req_valid[1] & ~req_valid[0];
    end
  end

  // The pointer moves to the other requester after every grant.
  always_ff @(posedge clk) begin
    if (rst)           rr <= 1'b0;
    else if (grant[0]) rr <= 1'b1;
    else if (grant[1]) rr <= 1'b0;
  end
`endif

  assign req_ready     = grant;
  assign validTri_R10H = |grant;
  assign tri_R10S      = grant[1] ? req_tri[1]   : req_tri[0];
  assign color_R10U    = grant[1] ? req_color[1] : req_color[0];

  // Hit side: halt delayed to line up with rast's outputs; its rising edge ends a subsequence.
  assign halt_d  = halt_p[OUT_DELAY-1];
  assign end_evt = halt_d & ~halt_d1;
  assign hit_act = ~halt_d & hit_valid_R18H;
  assign pop     = end_evt & first_seen & ~tag_empty;
  assign hit_o   = hit_R18S;
  assign color_o = color_R18U;

  always_comb begin
    hit_valid_o = '0;
    done_o      = '0;
    if (hit_act && !tag_empty) hit_valid_o[head] = 1'b1;
    if (pop)                   done_o[head]      = 1'b1;
  end

  // Tag storage holds data only; validity comes from the reset-cleared count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      halt_p     <= '0;
      halt_d1    <= 1'b0;
      first_seen <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      halt_p[0] <= halt_RnnnnL;
      for (int k = 1; k < OUT_DELAY; k++) halt_p[k] <= halt_p[k-1];
      halt_d1 <= halt_d;
      if (end_evt) first_seen <= 1'b1;
      if ((hit_act && tag_empty) || (end_evt && first_seen && tag_empty)) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rast_tri_sched.sv
// Directed bench for rast_tri_sched (default parameters); expectations follow
// RAST_TRI_SCHED_FIXED_PRIO_EN when that macro is defined.
module tb_rast_tri_sched;

  logic                              clk = 1'b0;
  logic                              rst;
  logic [1:0]                        req_valid;
  logic [1:0]                        req_ready;
  logic signed [1:0][2:0][2:0][23:0] req_tri;
  logic [1:0][2:0][23:0]             req_color;
  logic signed [2:0][2:0][23:0]      tri_R10S;
  logic [2:0][23:0]                  color_R10U;
  logic                              validTri_R10H;
  logic                              halt_RnnnnL;
  logic                              hit_valid_R18H;
  logic signed [2:0][23:0]           hit_R18S;
  logic [2:0][23:0]                  color_R18U;
  logic [1:0]                        hit_valid_o;
  logic signed [2:0][23:0]           hit_o;
  logic [2:0][23:0]                  color_o;
  logic [1:0]                        done_o;
  logic                              err_o;

  int n_cmp = 0;
  int n_err = 0;

  rast_tri_sched dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_tri(req_tri), .req_color(req_color), .tri_R10S(tri_R10S),
    .color_R10U(color_R10U), .validTri_R10H(validTri_R10H), .halt_RnnnnL(halt_RnnnnL),
    .hit_valid_R18H(hit_valid_R18H), .hit_R18S(hit_R18S), .color_R18U(color_R18U),
    .hit_valid_o(hit_valid_o), .hit_o(hit_o), .color_o(color_o), .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic h, input logic hv);
    req_valid      = v;
    halt_RnnnnL    = h;
    hit_valid_R18H = hv;
    #1;
  endtask

  task automatic idle(input int n, input logic h);
    repeat (n) begin
      drive(2'b00, h, 1'b0);
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(2'b00, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int r = 0; r < 2; r++)
      for (int v = 0; v < 3; v++) begin
        for (int a = 0; a < 3; a++) req_tri[r][v][a] = 24'(r * 100 + v * 10 + a + 1);
        req_color[r][v] = 24'(r * 1000 + v + 7);
      end
    hit_R18S   = '{24'd5, 24'd6, 24'd7};
    color_R18U = '{24'd9, 24'd8, 24'd3};

    // A: alternation with both valid until the tag FIFO fills
    do_reset();
    drive(2'b00, 1'b1, 1'b0);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_validtri", validTri_R10H, 1'b0);
    chk("rst_hitv", hit_valid_o, 2'b00);
    chk("rst_done", done_o, 2'b00);
    chk("rst_err", err_o, 1'b0);
    drive(2'b11, 1'b1, 1'b0);
    chk("a_g1", req_ready, 2'b01);
    chk("a_vt1", validTri_R10H, 1'b1);
    chk("a_tri1", tri_R10S, req_tri[0]);
    chk("a_col1", color_R10U, req_color[0]);
    tick();
    drive(2'b11, 1'b1, 1'b0);
`ifdef RAST_TRI_SCHED_FIXED_PRIO_EN
    chk("a_g2", req_ready, 2'b01);
    chk("a_tri2", tri_R10S, req_tri[0]);
`else
    chk("a_g2", req_ready, 2'b10);
    chk("a_tri2", tri_R10S, req_tri[1]);
    chk("a_col2", color_R10U, req_color[1]);
`endif
    tick();
    drive(2'b11, 1'b1, 1'b0);
    chk("a_g3", req_ready, 2'b01);
    tick();
    drive(2'b11, 1'b1, 1'b0);
`ifdef RAST_TRI_SCHED_FIXED_PRIO_EN
    chk("a_g4", req_ready, 2'b01);
`else
    chk("a_g4", req_ready, 2'b10);
`endif
    tick();
    drive(2'b11, 1'b1, 1'b0);
    chk("a_full_ready", req_ready, 2'b00);
    chk("a_full_vt", validTri_R10H, 1'b0);
    tick();
    drive(2'b00, 1'b1, 1'b0);
    chk("a_first_end_skipped", done_o, 2'b00);
    tick();

    // B: only requester 1 valid, then both
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b1, 1'b0);
      chk("b_only1", req_ready, 2'b10);
      tick();
    end
    drive(2'b11, 1'b1, 1'b0);
    chk("b_both_next0", req_ready, 2'b01);
    tick();

    // C: one triangle from requester 1, two hits, then the counted end
    do_reset();
    drive(2'b10, 1'b1, 1'b0);
    chk("c_issue1", req_ready, 2'b10);
    tick();
    idle(5, 1'b1);
    idle(3, 1'b0);
    idle(2, 1'b1);
    drive(2'b00, 1'b1, 1'b1);
    chk("c_hit1", hit_valid_o, 2'b10);
    chk("c_hit_data", hit_o, hit_R18S);
    chk("c_hit_color", color_o, color_R18U);
    tick();
    drive(2'b00, 1'b1, 1'b0);
    chk("c_gap", hit_valid_o, 2'b00);
    tick();
    drive(2'b00, 1'b1, 1'b1);
    chk("c_hit2", hit_valid_o, 2'b10);
    chk("c_done_early", done_o, 2'b00);
    tick();
    drive(2'b00, 1'b1, 1'b0);
    chk("c_done", done_o, 2'b10);
    chk("c_hitv_end", hit_valid_o, 2'b00);
    tick();
    drive(2'b00, 1'b1, 1'b0);
    chk("c_done_once", done_o, 2'b00);
    chk("c_no_err", err_o, 1'b0);
    tick();

    // D: hit while FIFO empty sets a sticky error
    do_reset();
    drive(2'b00, 1'b1, 1'b1);
    chk("d_no_strobe", hit_valid_o, 2'b00);
    chk("d_err_not_yet", err_o, 1'b0);
    tick();
    drive(2'b00, 1'b1, 1'b0);
    chk("d_err_set", err_o, 1'b1);
    tick();
    idle(3, 1'b1);
    drive(2'b00, 1'b1, 1'b0);
    chk("d_err_sticky", err_o, 1'b1);
    do_reset();
    drive(2'b00, 1'b1, 1'b0);
    chk("d_err_cleared", err_o, 1'b0);

    // E: full FIFO with a coincident counted end blocks issue for one cycle
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 1'b1, 1'b0);
      tick();
    end
    idle(2, 1'b1);
    idle(1, 1'b0);
    idle(5, 1'b1);
    drive(2'b01, 1'b1, 1'b0);
    chk("e_full_blocked", req_ready, 2'b00);
    chk("e_full_vt", validTri_R10H, 1'b0);
    chk("e_pop", done_o, 2'b01);
    tick();
    drive(2'b01, 1'b1, 1'b0);
    chk("e_issue_after", req_ready, 2'b01);
    chk("e_done_clear", done_o, 2'b00);
    tick();

    // F: reset with two tags outstanding discards them
    do_reset();
    drive(2'b10, 1'b1, 1'b0);
    chk("f_g1", req_ready, 2'b10);
    tick();
    drive(2'b01, 1'b1, 1'b0);
    chk("f_g0", req_ready, 2'b01);
    tick();
    rst = 1'b1;
    drive(2'b00, 1'b1, 1'b0);
    tick();
    rst = 1'b0;
    drive(2'b00, 1'b1, 1'b0);
    chk("f_ready0", req_ready, 2'b00);
    chk("f_vt0", validTri_R10H, 1'b0);
    chk("f_hitv0", hit_valid_o, 2'b00);
    chk("f_done0", done_o, 2'b00);
    chk("f_err0", err_o, 1'b0);
    tick();
    drive(2'b11, 1'b1, 1'b0);
    chk("f_rr_reset", req_ready, 2'b01);
    tick();
    idle(4, 1'b1);
    idle(1, 1'b0);
    idle(5, 1'b1);
    drive(2'b00, 1'b1, 1'b0);
    chk("f_done_new_tag_only", done_o, 2'b01);
    tick();
    drive(2'b00, 1'b1, 1'b0);
    chk("f_done_after", done_o, 2'b00);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rast_tri_sched.md
# rast_tri_sched

Two-requester triangle scheduler in front of `rast`. It arbitrates between two triangle sources and issues at most one triangle per cycle while `rast` is ready (`halt_RnnnnL`=1). It records the requester ID of every issued triangle in a tag FIFO. It then steers each triangle's hit subsequence back to the issuing requester, using the same halt-delay boundary detection the formal harness uses.

## Interface
Parameters:
- `SIGFIG`, 24, bits per position/color word
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex
- `COLORS`, 3, color channels
- `OUT_DELAY`, 5, cycles from `halt_RnnnnL` to aligned hit outputs (≥1)
- `TAG_DEPTH`, 4, tag FIFO entries (power of 2, ≥2)

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock
- `rst` in 1: synchronous active-high reset
- `req_valid` in 2: per-requester triangle valid
- `req_ready` out 2: per-requester accept, combinational
- `req_tri` in 2×VERTS×AXIS×SIGFIG signed: triangle per requester
- `req_color` in 2×COLORS×SIGFIG: color per requester
- `tri_R10S` out VERTS×AXIS×SIGFIG: to `rast`
- `color_R10U` out COLORS×SIGFIG: to `rast`
- `validTri_R10H` out 1: to `rast`
- `halt_RnnnnL` in 1: from `rast`; 1 = ready
- `hit_valid_R18H` in 1: from `rast`
- `hit_R18S` in AXIS×SIGFIG, `color_R18U` in COLORS×SIGFIG: from `rast`
- `hit_valid_o` out 2: per-requester hit strobe
- `hit_o`, `color_o` out: broadcast copies of `hit_R18S` and `color_R18U`
- `done_o` out 2: one-cycle pulse at the end of a requester's subsequence
- `err_o` out 1: sticky protocol error

## Operation
Issue:
- `can_issue = halt_RnnnnL & ~tag_full`.
- Round-robin pointer `rr` (reset 0). The pointed requester wins if valid; otherwise the other requester wins if valid.
- `req_ready[i] = can_issue & grant[i]`.
- `validTri_R10H = |grant`.
- Triangle/color outputs mux the granted requester's data. With no grant they carry requester 0's data, which is don't-care.
- On a grant to i, `rr <= ~i` next cycle.

Tag FIFO:
- Each issue pushes the granted ID.
- A pop happens on a counted subsequence end (below).
- Push and pop in the same cycle are legal, and the count is unchanged.
- Full blocks issue even if a pop is coincident.

Output steering:
- `halt_d` = `halt_RnnnnL` delayed by `OUT_DELAY`; `halt_d1` = `halt_d` delayed by 1. Both delay lines reset to 0.
- `end_evt = halt_d & ~halt_d1`.
- The first `end_evt` after reset is skipped, tracked by a `first_seen` flag reset to 0.
- While `~halt_d & hit_valid_R18H`:
  - If the FIFO is non-empty, `hit_valid_o[head]` = 1.
  - If the FIFO is empty, no strobe is driven and `err_o` is set.
- On a counted `end_evt`:
  - If the FIFO is non-empty, `done_o[head]` = 1 and the head is popped.
  - If the FIFO is empty, `err_o` is set and there is no pulse.
- `err_o` clears only on `rst`.

Reset values:
- `req_ready`, `validTri_R10H`, `hit_valid_o`, `done_o`, `err_o` are 0.
- FIFO is empty and `rr` = 0.

Mid-operation reset:
- Everything above returns to reset values on the next edge.
- Outstanding tags are discarded.
- No `done_o` pulse is emitted for discarded tags.

## Timing
- Issue is combinational in the cycle `halt_RnnnnL`=1; there is no added input latency.
- `rr`, FIFO push and FIFO pop update at the following edge.
- `hit_valid_o` and `done_o` are combinational from registered head/delay state plus the `hit_valid_R18H` input; they have zero added latency relative to `rast` outputs.
- Throughput:
  - One issue per cycle while `rast` stays ready.
  - Sustained alternation between requesters when both are valid.

## Configuration
- `RAST_TRI_SCHED_FIXED_PRIO_EN`:
  - Defined: requester 0 has strict priority, and `rr` is not instantiated.
  - Undefined (default): round-robin as above.

## Test plan
- Both requesters valid, `halt_RnnnnL`=1 for 4 cycles, `TAG_DEPTH`=4 → grants 0,1,0,1 and FIFO full. Cycle 5 with halt=1 → `req_ready`=00 and `validTri_R10H`=0.
- Only requester 1 valid for 3 cycles → 3 grants to 1. Then both valid → next grant to 0.
- Issue from requester 1. Drive `rast` with halt low for 3 cycles and 2 hit pulses → `hit_valid_o[1]` pulses twice, `hit_valid_o[0]` stays 0. `done_o`=10 on the second halt_d rising edge after reset (the first edge is skipped), and the FIFO becomes empty.
- `hit_valid_R18H`=1 while halt_d=0 with the FIFO empty → `err_o`=1, held until `rst`.
- FIFO full (4 tags) and a counted `end_evt` in the same cycle as a request → no issue that cycle; count drops to 3; issue succeeds the next cycle.
- `rst` asserted with 2 tags outstanding → next cycle FIFO empty, `rr`=0, all outputs 0, and no `done_o` pulse afterwards for the discarded tags.
- With `RAST_TRI_SCHED_FIXED_PRIO_EN` defined, both requesters valid for 3 cycles → grants 0,0,0.
